// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_e;

  // Command as queued: operands plus operation.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    alu_op_e    op;
  } alu_cmd_t;

  // Result as buffered for the consumer.
  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    alu_op_e    op;
    logic       div0;
  } alu_res_t;

  // Value reported in place of the ALU output for a divide by zero.
  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  // The only arithmetic this block does: flag a DIV whose divisor is zero.
  function automatic logic is_div0(input alu_cmd_t cmd);
    return (cmd.op == ALU_DIV) && (cmd.b == 8'd0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. The head is read straight from the
// storage array so an entry written at one edge is visible right after it.
// A push into a full FIFO is refused even if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Qualify requests against registered occupancy and compute next pointers.
  always_comb begin
    push_ok  = push && (count_q != FULL_CNT);
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds a non-stallable, 1-cycle registered ALU from a command queue and
// buffers its results behind valid/ready. Issue is credit-limited so every
// op in flight is guaranteed a slot in the result buffer.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_a,
  input  logic [7:0]                 in_b,
  input  logic [1:0]                 in_sel,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic [1:0]                 alu_sel,
  input  logic [7:0]                 alu_out,
  input  logic                       alu_carry,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_data,
  output logic                       res_carry,
  output logic [1:0]                 res_sel,
  output logic                       res_div0,
  output logic [$clog2(CMD_DEPTH):0] cmd_count
);

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RES_DEPTH) + 1;
  localparam int BW  = RCW + 1;
  localparam logic [CCW-1:0] CMD_FULL   = CCW'(CMD_DEPTH);
  localparam logic [BW-1:0]  RES_CREDIT = BW'(RES_DEPTH);

  alu_cmd_t       cmd_din, cmd_head;
  logic [CCW-1:0] cmd_cnt;
  logic           cmd_push, cmd_empty;

  alu_res_t       res_din, res_head, res_vis;
  logic [RCW-1:0] res_cnt;
  logic           res_push, res_pop;

  logic [BW-1:0]  busy;
  logic           issue;

  // ALU operand registers and the two-stage in-flight tracker.
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  alu_op_e    alu_sel_q, alu_sel_d;
  logic       p1_q, p1_d;
  alu_op_e    p1_op_q, p1_op_d;
  logic       p1_div0_q, p1_div0_d;
  logic       p2_q, p2_d;
  alu_op_e    p2_op_q, p2_op_d;
  logic       p2_div0_q, p2_div0_d;

  // Input side: accept only when the queue has room by registered count.
  always_comb begin
    in_ready  = (cmd_cnt < CMD_FULL);
    cmd_push  = in_valid && in_ready;
    cmd_empty = (cmd_cnt == '0);
    cmd_din   = '{a: in_a, b: in_b, op: alu_op_e'(in_sel)};
  end

  sync_fifo #(
    .WIDTH($bits(alu_cmd_t)),
    .DEPTH(CMD_DEPTH)
  ) u_cmd_q (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_push),
    .din  (cmd_din),
    .pop  (issue),
    .dout (cmd_head),
    .count(cmd_cnt)
  );

  // Credit check: ops in either ALU stage plus buffered results must leave a
  // free result slot. A same-cycle result pop is deliberately not counted.
  always_comb begin
    busy  = BW'(p1_q) + BW'(p2_q) + BW'(res_cnt);
    issue = !cmd_empty && (busy < RES_CREDIT);
  end

  // Next-state for ALU operands and the in-flight pipeline tags.
  always_comb begin
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    p1_d      = issue;
    p1_op_d   = p1_op_q;
    p1_div0_d = p1_div0_q;
    p2_d      = p1_q;
    p2_op_d   = p1_op_q;
    p2_div0_d = p1_div0_q;
    if (issue) begin
      alu_a_d   = cmd_head.a;
      alu_b_d   = cmd_head.b;
      alu_sel_d = cmd_head.op;
      p1_op_d   = cmd_head.op;
      p1_div0_d = is_div0(cmd_head);
    end
  end

  // Operand and tracker registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= ALU_ADD;
      p1_q      <= 1'b0;
      p1_op_q   <= ALU_ADD;
      p1_div0_q <= 1'b0;
      p2_q      <= 1'b0;
      p2_op_q   <= ALU_ADD;
      p2_div0_q <= 1'b0;
    end else begin
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      p1_q      <= p1_d;
      p1_op_q   <= p1_op_d;
      p1_div0_q <= p1_div0_d;
      p2_q      <= p2_d;
      p2_op_q   <= p2_op_d;
      p2_div0_q <= p2_div0_d;
    end
  end

  // Capture the ALU output one cycle after it registered the op; a divide by
  // zero reports a fixed value instead of whatever the ALU produced.
  always_comb begin
    res_push = p2_q;
    res_din  = '{data:  p2_div0_q ? DIV0_RESULT : alu_out,
                 carry: alu_carry,
                 op:    p2_op_q,
                 div0:  p2_div0_q};
    res_valid = (res_cnt != '0);
    res_pop   = res_valid && res_ready;
  end

  sync_fifo #(
    .WIDTH($bits(alu_res_t)),
    .DEPTH(RES_DEPTH)
  ) u_res_q (
    .clk  (clk),
    .rst  (rst),
    .push (res_push),
    .din  (res_din),
    .pop  (res_pop),
    .dout (res_head),
    .count(res_cnt)
  );

  // Result outputs read zero while the buffer is empty so no stale entry leaks.
  always_comb begin
    res_vis   = res_valid ? res_head : '0;
    res_data  = res_vis.data;
    res_carry = res_vis.carry;
    res_sel   = res_vis.op;
    res_div0  = res_vis.div0;
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign cmd_count = cmd_cnt;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural registered ALU.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [1:0] in_sel;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_out = 8'd0;
  logic       alu_carry = 1'b0;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic [1:0] res_sel;
  logic       res_div0;
  logic [2:0] cmd_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
    .res_sel(res_sel), .res_div0(res_div0),
    .cmd_count(cmd_count)
  );

  // Model of the external 8-bit ALU: registered output, carry of A+B.
  always @(posedge clk) begin
    logic [8:0] sum9;
    sum9 = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_sel)
      2'd0: alu_out <= alu_a + alu_b;
      2'd1: alu_out <= alu_a - alu_b;
      2'd2: alu_out <= 8'(alu_a * alu_b);
      default: alu_out <= (alu_b == 8'd0) ? 8'h00 : alu_a / alu_b;
    endcase
    alu_carry <= sum9[8];
  end

  // Backpressure vectors: 8 offered, first 6 accepted.
  logic [7:0] bp_a   [8] = '{8'd10, 8'd20, 8'd3, 8'd50, 8'd250, 8'd1, 8'h77, 8'h78};
  logic [7:0] bp_b   [8] = '{8'd1, 8'd1, 8'd4, 8'd5, 8'd10, 8'd2, 8'h11, 8'h12};
  logic [1:0] bp_s   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
  logic [7:0] bp_exp [6] = '{8'h0B, 8'h13, 8'h0C, 8'h0A, 8'h04, 8'hFF};
  logic       bp_cy  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one command until accepted (bounded); called at a negedge.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] s, output logic ok);
    in_a = a; in_b = b; in_sel = s; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result and let the next edge pop it; res_ready=1.
  task automatic get_result(output logic ok, output logic [7:0] d, output logic c,
                            output logic [1:0] s, output logic z);
    ok = 1'b0; d = 8'h00; c = 1'b0; s = 2'd0; z = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (res_valid) begin
        ok = 1'b1; d = res_data; c = res_carry; s = res_sel; z = res_div0;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    in_a = 8'd0; in_b = 8'd0; in_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (alu_a !== 8'd0) begin fails++; $display("FAIL reset_alu_a: got %h want 00", alu_a); end
    checks++; if (alu_b !== 8'd0) begin fails++; $display("FAIL reset_alu_b: got %h want 00", alu_b); end
    checks++; if (alu_sel !== 2'd0) begin fails++; $display("FAIL reset_alu_sel: got %0d want 0", alu_sel); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if ({res_data, res_carry, res_sel, res_div0} !== 12'd0) begin
      fails++; $display("FAIL reset_res_fields: got %h/%b/%0d/%b want 0", res_data, res_carry, res_sel, res_div0);
    end
    checks++; if (cmd_count !== 3'd0) begin fails++; $display("FAIL reset_cmd_count: got %0d want 0", cmd_count); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_latency();
    res_ready = 1'b1;
    in_a = 8'd200; in_b = 8'd100; in_sel = 2'd0; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    step();
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL lat_edge1: res_valid got %b want 0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL lat_edge2: res_valid got %b want 0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL lat_edge3: res_valid got %b want 1", res_valid); end
    checks++; if (res_data !== 8'h2C) begin fails++; $display("FAIL add_data: got %h want 2C", res_data); end
    checks++; if (res_carry !== 1'b1) begin fails++; $display("FAIL add_carry: got %b want 1", res_carry); end
    checks++; if (res_sel !== 2'd0 || res_div0 !== 1'b0) begin
      fails++; $display("FAIL add_tags: sel %0d div0 %b want 0/0", res_sel, res_div0);
    end
    step();
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL add_pop: res_valid got %b want 0", res_valid); end
  endtask

  task automatic test_sub_mul();
    logic ok1, ok2, c, z;
    logic [7:0] d;
    logic [1:0] s;
    push_cmd(8'd5, 8'd10, 2'd1, ok1);
    push_cmd(8'd16, 8'd17, 2'd2, ok2);
    checks++; if (!(ok1 && ok2)) begin fails++; $display("FAIL submul_push: got %b%b want 11", ok1, ok2); end
    get_result(ok1, d, c, s, z);
    checks++; if (!ok1 || d !== 8'hFB || c !== 1'b0 || s !== 2'd1 || z !== 1'b0) begin
      fails++; $display("FAIL sub_result: got ok=%b %h c%b s%0d z%b want FB c0 s1 z0", ok1, d, c, s, z);
    end
    get_result(ok1, d, c, s, z);
    checks++; if (!ok1 || d !== 8'h10 || c !== 1'b0 || s !== 2'd2 || z !== 1'b0) begin
      fails++; $display("FAIL mul_result: got ok=%b %h c%b s%0d z%b want 10 c0 s2 z0", ok1, d, c, s, z);
    end
  endtask

  task automatic test_div();
    logic ok1, ok2, c, z;
    logic [7:0] d;
    logic [1:0] s;
    push_cmd(8'd7, 8'd0, 2'd3, ok1);
    push_cmd(8'd100, 8'd7, 2'd3, ok2);
    checks++; if (!(ok1 && ok2)) begin fails++; $display("FAIL div_push: got %b%b want 11", ok1, ok2); end
    get_result(ok1, d, c, s, z);
    checks++; if (!ok1 || d !== 8'hFF || z !== 1'b1 || s !== 2'd3) begin
      fails++; $display("FAIL div0_result: got ok=%b %h z%b s%0d want FF z1 s3", ok1, d, z, s);
    end
    get_result(ok1, d, c, s, z);
    checks++; if (!ok1 || d !== 8'h0E || z !== 1'b0 || s !== 2'd3) begin
      fails++; $display("FAIL div_result: got ok=%b %h z%b s%0d want 0E z0 s3", ok1, d, z, s);
    end
  endtask

  // Fill everything with the consumer stalled, then release it while
  // checking same-cycle push/pop refusal and capture/pop overlap.
  task automatic test_backpressure();
    int accepted;
    logic ok, c, z;
    logic [7:0] d;
    logic [1:0] s;
    res_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      in_a = bp_a[i]; in_b = bp_b[i]; in_sel = bp_s[i]; in_valid = 1'b1;
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (accepted != 6) begin fails++; $display("FAIL bp_accepted: got %0d want 6", accepted); end
    checks++; if (cmd_count !== 3'd4) begin fails++; $display("FAIL bp_cmd_count: got %0d want 4", cmd_count); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (res_valid !== 1'b1 || res_data !== bp_exp[0]) begin
      fails++; $display("FAIL bp_head0: valid %b data %h want 1/%h", res_valid, res_data, bp_exp[0]);
    end
    // Pop one result; queue stays full so the offered command is refused.
    res_ready = 1'b1;
    in_a = 8'h55; in_b = 8'h00; in_sel = 2'd0; in_valid = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (cmd_count !== 3'd4 || in_ready !== 1'b0) begin
      fails++; $display("FAIL sim_full: cmd_count %0d in_ready %b want 4/0", cmd_count, in_ready);
    end
    // An issue pops the queue this cycle; the push must still be refused.
    step();
    in_valid = 1'b0;
    checks++; if (cmd_count !== 3'd3) begin fails++; $display("FAIL sim_pop_no_push: cmd_count got %0d want 3", cmd_count); end
    checks++; if (alu_a !== 8'd3 || alu_b !== 8'd4 || alu_sel !== 2'd2) begin
      fails++; $display("FAIL sim_issue: alu %h %h %0d want 03 04 2", alu_a, alu_b, alu_sel);
    end
    checks++; if (res_data !== bp_exp[1]) begin fails++; $display("FAIL sim_head1: got %h want %h", res_data, bp_exp[1]); end
    step();
    checks++; if (res_valid !== 1'b1 || res_data !== bp_exp[1]) begin
      fails++; $display("FAIL sim_stable: valid %b data %h want 1/%h", res_valid, res_data, bp_exp[1]);
    end
    // Next edge captures result 2 while result 1 pops.
    res_ready = 1'b1;
    step();
    checks++; if (res_valid !== 1'b1 || res_data !== bp_exp[2]) begin
      fails++; $display("FAIL sim_cap_pop: valid %b data %h want 1/%h", res_valid, res_data, bp_exp[2]);
    end
    for (int i = 2; i < 6; i++) begin
      get_result(ok, d, c, s, z);
      checks++; if (!ok || d !== bp_exp[i] || c !== bp_cy[i] || s !== bp_s[i] || z !== 1'b0) begin
        fails++; $display("FAIL bp_order%0d: got ok=%b %h c%b s%0d z%b want %h c%b s%0d z0",
                          i, ok, d, c, s, z, bp_exp[i], bp_cy[i], bp_s[i]);
      end
    end
    for (int i = 0; i < 5; i++) step();
    checks++; if (res_valid !== 1'b0 || cmd_count !== 3'd0) begin
      fails++; $display("FAIL bp_drained: res_valid %b cmd_count %0d want 0/0", res_valid, cmd_count);
    end
  endtask

  task automatic test_reset_mid();
    logic ok, c, z, stale;
    logic [7:0] d;
    logic [1:0] s;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a = 8'd40 + 8'(i); in_b = 8'd1; in_sel = 2'd0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_data !== 8'd41) begin
      fails++; $display("FAIL rmid_pre: valid %b data %h want 1/29", res_valid, res_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (res_valid !== 1'b0 || cmd_count !== 3'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_state: valid %b cmd_count %0d in_ready %b want 0/0/1", res_valid, cmd_count, in_ready);
    end
    checks++; if ({alu_a, alu_b, alu_sel} !== 18'd0 || {res_data, res_carry, res_sel, res_div0} !== 12'd0) begin
      fails++; $display("FAIL rmid_outputs: alu %h %h %0d res %h want zeros", alu_a, alu_b, alu_sel, res_data);
    end
    res_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) stale = 1'b1;
      step();
    end
    checks++; if (stale !== 1'b0) begin fails++; $display("FAIL rmid_stale: got result %b want none", stale); end
    push_cmd(8'd1, 8'd1, 2'd0, ok);
    get_result(ok, d, c, s, z);
    checks++; if (!ok || d !== 8'h02 || c !== 1'b0 || s !== 2'd0) begin
      fails++; $display("FAIL rmid_add: got ok=%b %h c%b s%0d want 02 c0 s0", ok, d, c, s);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sub_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
